// File: rtl/mem_req_arbiter_if.sv
// SRAM-like request/response channel used by the pipeline requesters and the bus bridge.
// The master drives the request and payload; the slave returns acceptance, response and read data.
interface mem_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like bus port between the instruction and data requesters with data-side priority.
// An in-order ID FIFO routes every bus response back to the requester that issued it.
module mem_req_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              reset,
    mem_req_arbiter_if.slave  inst,
    mem_req_arbiter_if.slave  data,
    mem_req_arbiter_if.master bus
);
    localparam int               PTR_W    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING);

    logic                   lock_valid_r;
    logic                   lock_id_r;
    logic [OUTSTANDING-1:0] id_fifo_r;
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;

    logic gid_s;
    logic granted_req_s;
    logic fifo_full_s;
    logic fifo_empty_s;
    logic head_id_s;
    logic issue_s;
    logic push_s;
    logic pop_s;

    // Grant selection: a pending lock pins the grant, otherwise data wins over inst.
    always_comb begin
        gid_s         = 1'b0;
        granted_req_s = 1'b0;
        if (lock_valid_r) begin
            gid_s = lock_id_r;
        end else if (data.req) begin
            gid_s = 1'b1;
        end else begin
            gid_s = 1'b0;
        end
        if (gid_s) begin
            granted_req_s = data.req;
        end else begin
            granted_req_s = inst.req;
        end
    end

    // Issue/push/pop qualifiers; full is taken from the registered count so a same-cycle pop cannot unblock issue.
    always_comb begin
        fifo_full_s  = (count_r == FULL_CNT);
        fifo_empty_s = (count_r == {CNT_W{1'b0}});
        head_id_s    = id_fifo_r[rd_ptr_r];
        issue_s      = granted_req_s & ~fifo_full_s & ~reset;
        push_s       = issue_s & bus.addr_ok;
        pop_s        = bus.data_ok & ~fifo_empty_s & ~reset;
    end

    // Bus request and payload mux from the granted requester.
    always_comb begin
        bus.req = issue_s;
        if (gid_s) begin
            bus.wr    = data.wr;
            bus.size  = data.size;
            bus.addr  = data.addr;
            bus.wstrb = data.wstrb;
            bus.wdata = data.wdata;
        end else begin
            bus.wr    = inst.wr;
            bus.size  = inst.size;
            bus.addr  = inst.addr;
            bus.wstrb = inst.wstrb;
            bus.wdata = inst.wdata;
        end
    end

    // Acceptance goes to the granted side; responses go to the FIFO head's owner.
    always_comb begin
        inst.addr_ok = push_s & ~gid_s;
        data.addr_ok = push_s & gid_s;
        inst.data_ok = pop_s & ~head_id_s;
        data.data_ok = pop_s & head_id_s;
        inst.rdata   = bus.rdata;
        data.rdata   = bus.rdata;
    end

    // Grant lock: held from an unaccepted issue until the bus accepts the address.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_valid_r <= 1'b0;
            lock_id_r    <= 1'b0;
        end else if (issue_s && !bus.addr_ok) begin
            lock_valid_r <= 1'b1;
            lock_id_r    <= gid_s;
        end else if (push_s) begin
            lock_valid_r <= 1'b0;
        end
    end

    // In-order ID FIFO; pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_fifo_r <= {OUTSTANDING{1'b0}};
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                id_fifo_r[wr_ptr_r] <= gid_s;
                wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios with literal expectations plus randomized traffic,
// all cycles checked against a queue-based reference model of the arbitration rules.
module tb_mem_req_arbiter;
    localparam int OUTSTANDING = 2;

    logic clk;
    logic reset;
    int   tests;
    int   failed;

    mem_req_arbiter_if inst_if ();
    mem_req_arbiter_if data_if ();
    mem_req_arbiter_if bus_if ();

    mem_req_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
        .clk   (clk),
        .reset (reset),
        .inst  (inst_if),
        .data  (data_if),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: lock flag plus a queue of requester ids (0 inst, 1 data)
    bit          m_lock;
    bit          m_lock_id;
    bit          m_q[$];
    bit          e_gid;
    bit          e_greq;
    bit          e_issue;
    bit          e_pop;
    bit          e_head;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [6:0]  e_ctl;

    always @(negedge clk) begin
        if (reset) begin
            check("rst_bus_req", bus_if.req, 0);
            check("rst_inst_addr_ok", inst_if.addr_ok, 0);
            check("rst_data_addr_ok", data_if.addr_ok, 0);
            check("rst_inst_data_ok", inst_if.data_ok, 0);
            check("rst_data_data_ok", data_if.data_ok, 0);
            m_lock = 0;
            m_q.delete();
        end else begin
            e_gid   = m_lock ? m_lock_id : data_if.req;
            e_greq  = e_gid ? data_if.req : inst_if.req;
            e_issue = e_greq && (m_q.size() < OUTSTANDING);
            e_pop   = bus_if.data_ok && (m_q.size() > 0);
            e_head  = (m_q.size() > 0) ? m_q[0] : 1'b0;
            check("mdl_bus_req", bus_if.req, e_issue);
            if (e_issue) begin
                e_addr  = e_gid ? data_if.addr : inst_if.addr;
                e_wdata = e_gid ? data_if.wdata : inst_if.wdata;
                e_ctl   = e_gid ? {data_if.wr, data_if.size, data_if.wstrb}
                                : {inst_if.wr, inst_if.size, inst_if.wstrb};
                check("mdl_bus_addr", bus_if.addr, e_addr);
                check("mdl_bus_wdata", bus_if.wdata, e_wdata);
                check("mdl_bus_ctl", {bus_if.wr, bus_if.size, bus_if.wstrb}, e_ctl);
            end
            check("mdl_inst_addr_ok", inst_if.addr_ok, e_issue && bus_if.addr_ok && !e_gid);
            check("mdl_data_addr_ok", data_if.addr_ok, e_issue && bus_if.addr_ok && e_gid);
            check("mdl_inst_data_ok", inst_if.data_ok, e_pop && !e_head);
            check("mdl_data_data_ok", data_if.data_ok, e_pop && e_head);
            check("mdl_inst_rdata", inst_if.rdata, bus_if.rdata);
            check("mdl_data_rdata", data_if.rdata, bus_if.rdata);
            if (e_pop) void'(m_q.pop_front());
            if (e_issue && bus_if.addr_ok) begin
                m_q.push_back(e_gid);
                m_lock = 0;
            end else if (e_issue) begin
                m_lock    = 1;
                m_lock_id = e_gid;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_inst(input logic r, input logic [31:0] a);
        inst_if.req = r; inst_if.addr = a; inst_if.wr = 1'b0;
        inst_if.size = 2'd2; inst_if.wstrb = 4'h0; inst_if.wdata = 32'h0;
    endtask

    task automatic drive_data(input logic r, input logic [31:0] a);
        data_if.req = r; data_if.addr = a; data_if.wr = 1'b0;
        data_if.size = 2'd2; data_if.wstrb = 4'h0; data_if.wdata = 32'h0;
    endtask

    logic i_acc;
    logic d_acc;

    initial begin
        tests = 0; failed = 0;
        reset = 1'b1;
        drive_inst(1'b1, 32'h1C000000);
        drive_data(1'b1, 32'h80000000);
        bus_if.addr_ok = 1'b1; bus_if.data_ok = 1'b1; bus_if.rdata = 32'h0;
        @(negedge clk);
        check("reset_bus_req", bus_if.req, 0);
        check("reset_data_data_ok", data_if.data_ok, 0);
        tick(); tick();
        reset = 1'b0;
        drive_inst(1'b0, 32'h0); drive_data(1'b0, 32'h0);
        bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0;
        tick();

        // solo inst read
        drive_inst(1'b1, 32'h1C000000); bus_if.addr_ok = 1'b1;
        @(negedge clk);
        check("solo_bus_addr", bus_if.addr, 32'h1C000000);
        check("solo_inst_addr_ok", inst_if.addr_ok, 1);
        check("solo_data_addr_ok", data_if.addr_ok, 0);
        tick(); inst_if.req = 1'b0; bus_if.addr_ok = 1'b0;
        @(negedge clk);
        check("solo_addr_ok_once", inst_if.addr_ok, 0);
        tick(); bus_if.data_ok = 1'b1; bus_if.rdata = 32'h12345678;
        @(negedge clk);
        check("solo_inst_data_ok", inst_if.data_ok, 1);
        check("solo_inst_rdata", inst_if.rdata, 32'h12345678);
        check("solo_data_data_ok", data_if.data_ok, 0);
        tick(); bus_if.data_ok = 1'b0;

        // priority
        drive_inst(1'b1, 32'h1C000100); drive_data(1'b1, 32'h80000040); bus_if.addr_ok = 1'b1;
        @(negedge clk);
        check("pri_first_addr", bus_if.addr, 32'h80000040);
        check("pri_data_addr_ok", data_if.addr_ok, 1);
        check("pri_inst_waits", inst_if.addr_ok, 0);
        tick(); data_if.req = 1'b0;
        @(negedge clk);
        check("pri_second_addr", bus_if.addr, 32'h1C000100);
        check("pri_inst_addr_ok", inst_if.addr_ok, 1);
        tick(); inst_if.req = 1'b0; bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b1; bus_if.rdata = 32'hD1;
        @(negedge clk);
        check("pri_resp1_data", data_if.data_ok, 1);
        check("pri_resp1_inst", inst_if.data_ok, 0);
        tick(); bus_if.rdata = 32'hD2;
        @(negedge clk);
        check("pri_resp2_inst", inst_if.data_ok, 1);
        tick(); bus_if.data_ok = 1'b0;

        // lock
        drive_inst(1'b1, 32'h1C000200); bus_if.addr_ok = 1'b0;
        @(negedge clk);
        check("lock_c1_addr", bus_if.addr, 32'h1C000200);
        tick(); drive_data(1'b1, 32'h80000080);
        @(negedge clk);
        check("lock_c2_addr", bus_if.addr, 32'h1C000200);
        check("lock_c2_data_addr_ok", data_if.addr_ok, 0);
        tick();
        @(negedge clk);
        check("lock_c3_addr", bus_if.addr, 32'h1C000200);
        tick(); bus_if.addr_ok = 1'b1;
        @(negedge clk);
        check("lock_accept_addr", bus_if.addr, 32'h1C000200);
        check("lock_accept_inst", inst_if.addr_ok, 1);
        tick(); inst_if.req = 1'b0;
        @(negedge clk);
        check("lock_then_data_addr", bus_if.addr, 32'h80000080);
        check("lock_then_data_ok", data_if.addr_ok, 1);
        tick(); data_if.req = 1'b0; bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b1;
        @(negedge clk);
        check("lock_resp_inst", inst_if.data_ok, 1);
        tick();
        @(negedge clk);
        check("lock_resp_data", data_if.data_ok, 1);
        tick(); bus_if.data_ok = 1'b0;

        // full
        drive_data(1'b1, 32'h80000100); bus_if.addr_ok = 1'b1;
        @(negedge clk); check("full_acc1", data_if.addr_ok, 1);
        tick(); drive_data(1'b1, 32'h80000104);
        @(negedge clk); check("full_acc2", data_if.addr_ok, 1);
        tick(); data_if.req = 1'b0; drive_inst(1'b1, 32'h1C000300);
        @(negedge clk);
        check("full_blocks_req", bus_if.req, 0);
        check("full_blocks_aok", inst_if.addr_ok, 0);
        tick(); bus_if.data_ok = 1'b1; bus_if.rdata = 32'hE1;
        @(negedge clk);
        check("full_pop_same_cycle_req", bus_if.req, 0);
        check("full_pop_data_ok", data_if.data_ok, 1);
        tick(); bus_if.data_ok = 1'b0;
        @(negedge clk);
        check("full_unblocked_req", bus_if.req, 1);
        check("full_unblocked_aok", inst_if.addr_ok, 1);
        tick(); inst_if.req = 1'b0; bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b1;
        @(negedge clk); check("full_drain_data", data_if.data_ok, 1);
        tick();
        @(negedge clk); check("full_drain_inst", inst_if.data_ok, 1);
        tick(); bus_if.data_ok = 1'b0;

        // ordering: data, inst, data with responses 0xA, 0xB, 0xC
        drive_data(1'b1, 32'h80000200); bus_if.addr_ok = 1'b1;
        @(negedge clk); check("ord_acc_data1", data_if.addr_ok, 1);
        tick(); data_if.req = 1'b0; drive_inst(1'b1, 32'h1C000400);
        @(negedge clk); check("ord_acc_inst", inst_if.addr_ok, 1);
        tick(); inst_if.req = 1'b0; drive_data(1'b1, 32'h80000204);
        bus_if.data_ok = 1'b1; bus_if.rdata = 32'hA;
        @(negedge clk);
        check("ord_full_req", bus_if.req, 0);
        check("ord_resp_a_data", data_if.data_ok, 1);
        check("ord_resp_a_inst", inst_if.data_ok, 0);
        check("ord_resp_a_rdata", data_if.rdata, 32'hA);
        tick(); bus_if.rdata = 32'hB;
        @(negedge clk);
        check("ord_acc_data2", data_if.addr_ok, 1);
        check("ord_resp_b_inst", inst_if.data_ok, 1);
        check("ord_resp_b_data", data_if.data_ok, 0);
        check("ord_resp_b_rdata", inst_if.rdata, 32'hB);
        tick(); data_if.req = 1'b0; bus_if.addr_ok = 1'b0; bus_if.rdata = 32'hC;
        @(negedge clk);
        check("ord_resp_c_data", data_if.data_ok, 1);
        check("ord_resp_c_rdata", data_if.rdata, 32'hC);
        tick(); bus_if.data_ok = 1'b0;

        // reset with two outstanding, then spurious responses
        drive_data(1'b1, 32'h80000300); bus_if.addr_ok = 1'b1;
        @(negedge clk); check("rs_acc_data", data_if.addr_ok, 1);
        tick(); data_if.req = 1'b0; drive_inst(1'b1, 32'h1C000500);
        @(negedge clk); check("rs_acc_inst", inst_if.addr_ok, 1);
        tick(); inst_if.req = 1'b0; bus_if.addr_ok = 1'b0; reset = 1'b1;
        tick(); reset = 1'b0; bus_if.data_ok = 1'b1;
        @(negedge clk);
        check("spur1_inst", inst_if.data_ok, 0);
        check("spur1_data", data_if.data_ok, 0);
        tick();
        @(negedge clk);
        check("spur2_inst", inst_if.data_ok, 0);
        check("spur2_data", data_if.data_ok, 0);
        tick(); bus_if.data_ok = 1'b0; drive_inst(1'b1, 32'h1C000600); bus_if.addr_ok = 1'b1;
        @(negedge clk);
        check("rs_next_req", bus_if.req, 1);
        check("rs_next_aok", inst_if.addr_ok, 1);
        tick(); inst_if.req = 1'b0; bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b1;
        @(negedge clk); check("rs_next_resp", inst_if.data_ok, 1);
        tick(); bus_if.data_ok = 1'b0;

        // randomized traffic honouring the hold-until-accepted rule
        i_acc = 1'b0; d_acc = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (!inst_if.req || i_acc) begin
                inst_if.req   = ($urandom_range(0, 99) < 55);
                inst_if.wr    = 1'($urandom_range(0, 1));
                inst_if.size  = 2'($urandom_range(0, 3));
                inst_if.addr  = $urandom;
                inst_if.wstrb = 4'($urandom_range(0, 15));
                inst_if.wdata = $urandom;
            end
            if (!data_if.req || d_acc) begin
                data_if.req   = ($urandom_range(0, 99) < 55);
                data_if.wr    = 1'($urandom_range(0, 1));
                data_if.size  = 2'($urandom_range(0, 3));
                data_if.addr  = $urandom;
                data_if.wstrb = 4'($urandom_range(0, 15));
                data_if.wdata = $urandom;
            end
            bus_if.addr_ok = 1'($urandom_range(0, 1));
            bus_if.data_ok = ($urandom_range(0, 99) < 45);
            bus_if.rdata   = $urandom;
            @(negedge clk);
            i_acc = inst_if.addr_ok;
            d_acc = data_if.addr_ok;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
